// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: fault codes, clear-FSM states
// and the even-parity helper used when DMEM_PARITY_EN is defined.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_PARITY   = 2'b11
  } err_code_t;

  typedef enum logic {
    CLR_CLEAR = 1'b0,
    CLR_READY = 1'b1
  } clr_state_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [WORD_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Processor DMEM port bundle. Data words are big-endian: byte lane 0 is the
// most significant byte ([31:24]); sub-word store data is right-justified.
interface dmem_if;
  import dmem_pkg::*;

  logic [WORD_W-1:0] addr_to_mem;
  logic              write_enable_to_mem;
  logic              byte_to_mem;
  logic              half_word_to_mem;
  logic              sign_extend_to_mem;
  logic [WORD_W-1:0] data_to_mem;
  logic              mem_access;
  logic [WORD_W-1:0] data_from_mem;

  modport master (
    output addr_to_mem, write_enable_to_mem, byte_to_mem, half_word_to_mem,
           sign_extend_to_mem, data_to_mem, mem_access,
    input  data_from_mem
  );

  modport slave (
    input  addr_to_mem, write_enable_to_mem, byte_to_mem, half_word_to_mem,
           sign_extend_to_mem, data_to_mem, mem_access,
    output data_from_mem
  );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: extracts and extends sub-word loads, merges
// sub-word stores into the current word, and flags misaligned accesses.
// Byte lane 0 is the most significant byte of the word.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic              is_byte,
  input  logic              is_half,
  input  logic              sign_extend,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged,
  output logic              misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Select the addressed lane(s) for loads and splice store data into the word.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    load_data = word;
    merged    = store_data;
    sel_byte  = word[31:24];
    sel_half  = word[31:16];
    if (is_byte) begin
      merged = word;
      case (lane)
        2'd0: begin sel_byte = word[31:24]; merged[31:24] = store_data[7:0]; end
        2'd1: begin sel_byte = word[23:16]; merged[23:16] = store_data[7:0]; end
        2'd2: begin sel_byte = word[15:8];  merged[15:8]  = store_data[7:0]; end
        default: begin sel_byte = word[7:0]; merged[7:0] = store_data[7:0]; end
      endcase
      load_data = {{24{sign_extend & sel_byte[7]}}, sel_byte};
    end else if (is_half) begin
      merged = word;
      if (lane[1]) begin
        sel_half      = word[15:0];
        merged[15:0] = store_data[15:0];
      end else begin
        sel_half       = word[31:16];
        merged[31:16] = store_data[15:0];
      end
      load_data = {{16{sign_extend & sel_half[15]}}, sel_half};
    end
  end

  // Byte accesses are always aligned; byte wins over half when both are set.
  assign misalign = is_byte ? 1'b0 : (is_half ? lane[0] : (lane != 2'd0));

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder on the far end of the processor DMEM port.
// Loads are combinational, stores commit on the clock edge, a clear FSM
// zero-fills the array after reset or on scrub_req, and a sticky fault
// register captures the first misaligned / out-of-range (/ parity) access.
// Optional feature: define DMEM_PARITY_EN to store one even-parity bit per word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic          clock,
  input  logic          reset,
  dmem_if.slave         bus,
  input  logic          scrub_req,
  output logic          mem_ready,
  input  logic          err_clear,
  output logic          err_valid,
  output err_code_t     err_code,
  output logic [31:0]   err_addr,
  input  logic          parity_flip_in
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  clr_state_t        state;
  logic [IDX_W-1:0]  idx;

  logic [31:0]       offset;
  logic [IDX_W-1:0]  word_idx;
  logic [32:0]       addr_ext, base_ext, limit_ext;
  logic              in_range, misalign, ready, access_ok, store_en;
  logic [WORD_W-1:0] rd_word, load_data, merged;
  err_code_t         fault_code;

  assign ready     = (state == CLR_READY);
  assign offset    = bus.addr_to_mem - BASE_ADDR;
  assign word_idx  = IDX_W'(offset >> 2);
  // Window check in 33 bits so a window touching 4 GiB cannot wrap.
  assign addr_ext  = {1'b0, bus.addr_to_mem};
  assign base_ext  = {1'b0, BASE_ADDR};
  assign limit_ext = base_ext + (33'(DEPTH) << 2);
  assign in_range  = (addr_ext >= base_ext) && (addr_ext < limit_ext);
  assign rd_word   = mem[word_idx];

  dmem_lane_fmt u_lane_fmt (
    .word        (rd_word),
    .lane        (bus.addr_to_mem[1:0]),
    .is_byte     (bus.byte_to_mem),
    .is_half     (bus.half_word_to_mem),
    .sign_extend (bus.sign_extend_to_mem),
    .store_data  (bus.data_to_mem),
    .load_data   (load_data),
    .merged      (merged),
    .misalign    (misalign)
  );

  assign access_ok         = ready && !misalign && in_range;
  assign store_en          = access_ok && bus.write_enable_to_mem;
  assign bus.data_from_mem = access_ok ? load_data : '0;

`ifdef DMEM_PARITY_EN
  logic par [DEPTH];
  logic par_bad;

  assign par_bad = (even_parity(rd_word) != par[word_idx]);

  // Parity bits follow the data array: zero on clear, recomputed on store.
  always_ff @(posedge clock) begin
    if (state == CLR_CLEAR)
      par[idx] <= 1'b0;
    else if (store_en)
      par[word_idx] <= even_parity(merged) ^ parity_flip_in;
  end
`else
  logic par_bad;
  logic unused_parity;

  assign par_bad       = 1'b0;
  assign unused_parity = parity_flip_in;
`endif

  // Classify this cycle's access; misaligned outranks out-of-range outranks parity.
  always_comb begin
    fault_code = ERR_NONE;
    if (ready && bus.mem_access) begin
      if (misalign)
        fault_code = ERR_MISALIGN;
      else if (!in_range)
        fault_code = ERR_RANGE;
      else if (!bus.write_enable_to_mem && par_bad)
        fault_code = ERR_PARITY;
    end
  end

  // Data array: the clear FSM owns the write port while clearing.
  // NOTE: the array has no reset branch; the clear FSM zero-fills it instead,
  // which keeps it mappable onto RAM.
  always_ff @(posedge clock) begin
    if (state == CLR_CLEAR)
      mem[idx] <= '0;
    else if (store_en)
      mem[word_idx] <= merged;
  end

  // Clear FSM: one word per cycle, then READY until a scrub request.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLR_CLEAR;
      idx       <= '0;
      mem_ready <= 1'b0;
    end else begin
      case (state)
        CLR_CLEAR: begin
          if (idx == IDX_W'(DEPTH - 1)) begin
            state     <= CLR_READY;
            idx       <= '0;
            mem_ready <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          if (scrub_req) begin
            state     <= CLR_CLEAR;
            idx       <= '0;
            mem_ready <= 1'b0;
          end
        end
      endcase
    end
  end

  // Sticky fault register: first fault wins until cleared; a clear in the
  // same cycle as a new fault captures the new one.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      err_addr  <= '0;
    end else if (fault_code != ERR_NONE && (!err_valid || err_clear)) begin
      err_valid <= 1'b1;
      err_code  <= fault_code;
      err_addr  <= bus.addr_to_mem;
    end else if (err_clear) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      err_addr  <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=16, BASE_ADDR=0) with
// hand-computed expectations; honours DMEM_PARITY_EN for the parity case.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        scrub_req;
  logic        mem_ready;
  logic        err_clear;
  logic        err_valid;
  err_code_t   err_code;
  logic [31:0] err_addr;
  logic        parity_flip_in;
  int          checks = 0;
  int          errors = 0;
  int          n;

  dmem_if bus ();

  dmem_responder #(.DEPTH(16), .BASE_ADDR(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .scrub_req      (scrub_req),
    .mem_ready      (mem_ready),
    .err_clear      (err_clear),
    .err_valid      (err_valid),
    .err_code       (err_code),
    .err_addr       (err_addr),
    .parity_flip_in (parity_flip_in)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic we, input logic is_byte,
                       input logic is_half, input logic sext, input logic [31:0] data,
                       input logic access);
    bus.addr_to_mem         = addr;
    bus.write_enable_to_mem = we;
    bus.byte_to_mem         = is_byte;
    bus.half_word_to_mem    = is_half;
    bus.sign_extend_to_mem  = sext;
    bus.data_to_mem         = data;
    bus.mem_access          = access;
    #1;
  endtask

  initial begin
    reset = 1'b1; scrub_req = 1'b0; err_clear = 1'b0; parity_flip_in = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); tick(); tick();
    reset = 1'b0;

    // 1. Reset state and clear duration
    check("rst_ready", mem_ready, 1'b0);
    check("rst_err_valid", err_valid, 1'b0);
    check("rst_err_code", 32'(err_code), 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_data", bus.data_from_mem, 32'h0);
    n = 0;
    while (!mem_ready && n < 40) begin tick(); n++; end
    check("clear_cycles", n, 16);
    for (int i = 0; i < 16; i++) begin
      drive(32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("init_zero", bus.data_from_mem, 32'h0);
    end

    // 2. Word store, then byte and half loads
    drive(32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11223344, 1'b1);
    tick();
    drive(32'hB, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("byte_ld_b", bus.data_from_mem, 32'h00000044);
    drive(32'h8, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1);
    check("half_ld_8", bus.data_from_mem, 32'h00001122);
    drive(32'hA, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1);
    check("half_ld_a", bus.data_from_mem, 32'h00003344);

    // 3. Byte store preserves other lanes; sign extension
    drive(32'h9, 1'b1, 1'b1, 1'b0, 1'b0, 32'h000000F0, 1'b1);
    check("no_bypass", bus.data_from_mem, 32'h00000022);
    tick();
    drive(32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("word_after_byte", bus.data_from_mem, 32'h11F03344);
    drive(32'h9, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    check("byte_sext", bus.data_from_mem, 32'hFFFFFFF0);
    drive(32'h9, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("byte_zext", bus.data_from_mem, 32'h000000F0);
    drive(32'hA, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000BEEF, 1'b1);
    tick();
    drive(32'hA, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1);
    check("half_sext", bus.data_from_mem, 32'hFFFFBEEF);
    drive(32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("word_after_half", bus.data_from_mem, 32'h11F0BEEF);

    // 4. Misaligned store, sticky fault, clear, range boundary
    drive(32'h6, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    check("mis_data", bus.data_from_mem, 32'h0);
    tick();
    check("mis_valid", err_valid, 1'b1);
    check("mis_code", 32'(err_code), 32'h1);
    check("mis_addr", err_addr, 32'h6);
    drive(32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("mis_dropped", bus.data_from_mem, 32'h0);
    drive(32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("oor_data", bus.data_from_mem, 32'h0);
    tick();
    check("sticky_code", 32'(err_code), 32'h1);
    check("sticky_addr", err_addr, 32'h6);
    drive(32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("clr_valid", err_valid, 1'b0);
    check("clr_code", 32'(err_code), 32'h0);
    drive(32'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    check("last_word_ok", err_valid, 1'b0);
    drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    check("range_valid", err_valid, 1'b1);
    check("range_code", 32'(err_code), 32'h2);
    check("range_addr", err_addr, 32'h40);
    drive(32'h41, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    err_clear = 1'b1;
    tick();
    check("clr_new_valid", err_valid, 1'b1);
    check("clr_new_code", 32'(err_code), 32'h1);
    check("clr_new_addr", err_addr, 32'h41);
    drive(32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    err_clear = 1'b0;
    drive(32'h6, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("noacc_mis_data", bus.data_from_mem, 32'h0);
    tick();
    check("noacc_no_fault", err_valid, 1'b0);
    drive(32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("noacc_load", bus.data_from_mem, 32'h11F0BEEF);

    // 5. Scrub: stores and faults dropped while clearing; scrub ignored mid-clear
    drive(32'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1);
    tick();
    drive(32'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("pre_scrub", bus.data_from_mem, 32'h12345678);
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    check("scrub_ready_low", mem_ready, 1'b0);
    check("scrub_data", bus.data_from_mem, 32'h0);
    n = 0;
    for (int i = 0; i < 7; i++) begin tick(); n++; end
    drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hAAAAAAAA, 1'b1);
    scrub_req = 1'b1;
    tick(); n++;
    scrub_req = 1'b0;
    drive(32'h6, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(); n++;
    drive(32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    while (!mem_ready && n < 40) begin tick(); n++; end
    check("scrub_cycles", n, 16);
    check("scrub_no_fault", err_valid, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("scrub_w0", bus.data_from_mem, 32'h0);
    drive(32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("scrub_w2", bus.data_from_mem, 32'h0);
    drive(32'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("scrub_w15", bus.data_from_mem, 32'h0);

    // 6. Inverted parity on store
    drive(32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b1);
    parity_flip_in = 1'b1;
    tick();
    parity_flip_in = 1'b0;
    drive(32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("par_data", bus.data_from_mem, 32'h00000001);
    tick();
`ifdef DMEM_PARITY_EN
    check("par_valid", err_valid, 1'b1);
    check("par_code", 32'(err_code), 32'h3);
    check("par_addr", err_addr, 32'h4);
`else
    check("par_valid", err_valid, 1'b0);
    check("par_code", 32'(err_code), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
